img_lut_loader: RTL and testbench
=================================

IMG_LUT_LOADER -- requirements
Module: img_lut_loader

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 10, pixel/LUT data and address width; table depth is 2**PX_WIDTH.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  one-cycle pulse requesting a full table reload.
REQ-005 SHALL have port sof_i  input  1  start-of-frame pulse from the video path (tuser & tvalid & tready of the pixel stream).
REQ-006 SHALL have port lut_data_i  axi4_stream_if.slave  TDATA_WIDTH  table entries in ascending address order, tlast on the final entry.
REQ-007 SHALL have port img_lut_ctrl_o  img_lut_ctrl_if.master  PX_WIDTH  write port (orig_px, mod_px, wr_stb) into the pixel LUT.
REQ-008 SHALL have port busy_o  output  1  high from accepted start until load end.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse at load end.
REQ-010 SHALL have port err_o  output  1  sticky table-length error, cleared by the next accepted start.

Function
REQ-011 SHALL implement FSM IDLE -> WAIT_SOF -> LOAD -> DRAIN -> IDLE.
REQ-012 In IDLE, start_i SHALL move to WAIT_SOF, clear err_o and the address counter; start_i outside IDLE SHALL be ignored.
REQ-013 In WAIT_SOF, sof_i SHALL move to LOAD on the next cycle; lut_data_i.tready SHALL be 0.
REQ-014 In LOAD, lut_data_i.tready SHALL be 1; each accepted beat SHALL produce wr_stb=1 exactly one cycle later with orig_px = counter value at acceptance, mod_px = tdata[PX_WIDTH-1:0].
REQ-015 Counter SHALL increment per accepted beat, PX_WIDTH+1 bits wide, no wrap.
REQ-016 Beat with tlast at address 2**PX_WIDTH-1 SHALL end load: IDLE, done_o pulse coincident with last wr_stb, err_o unchanged.
REQ-017 tlast at address < 2**PX_WIDTH-1 (short table) SHALL be written, then end load with done_o and err_o=1.
REQ-018 Beat at address 2**PX_WIDTH-1 without tlast (long table) SHALL be written, set err_o=1, enter DRAIN.
REQ-019 In DRAIN, tready SHALL be 1, beats discarded (no wr_stb) until tlast accepted, then IDLE with done_o.
REQ-020 wr_stb SHALL be 0 in all cycles except REQ-014 cycles; orig_px/mod_px upper interface bits SHALL be zero.
REQ-021 sof_i during LOAD/DRAIN SHALL be ignored.
REQ-022 busy_o SHALL equal (state != IDLE).

Reset
REQ-023 rst_i SHALL return FSM to IDLE and zero counter, wr_stb, orig_px, mod_px, tready, busy_o, done_o, err_o on the next edge.
REQ-024 rst_i mid-load SHALL abort with no further wr_stb; partially written LUT content is not restored.

Configuration
REQ-025 Macro IMG_LUT_LOADER_FRAME_SYNC_EN defined: WAIT_SOF behaves per REQ-013.
REQ-026 Macro undefined: WAIT_SOF state SHALL not exist; start_i SHALL move IDLE -> LOAD directly and sof_i SHALL be unused.

Structure
REQ-027 Shared package img_proc_pkg SHALL hold the FSM state enum and the TDATA_WIDTH byte-rounding function (PX_WIDTH rounded up to a multiple of 8).
REQ-028 No sub-module; single flat module.

Verification
REQ-029 PX_WIDTH=10, start, sof after 5 cycles, 1024 beats tdata=1023-i, tlast on 1023 -> 1024 wr_stb with orig_px=i, mod_px=1023-i; done_o once; err_o=0.
REQ-030 Short table: tlast on beat 99 -> 100 writes, done_o, err_o=1; next start clears err_o.
REQ-031 Long table: 1030 beats, tlast on last -> 1024 writes, 6 beats dropped, err_o=1, done_o after beat 1029.
REQ-032 FRAME_SYNC_EN: data valid before sof_i -> tready=0, no wr_stb until cycle after sof_i; without macro writes start right after start_i.
REQ-033 Random tvalid gaps plus rst_i asserted at beat 500 -> no wr_stb after reset edge, all outputs 0, new start completes cleanly.

Source files
------------

// File: rtl/img_proc_pkg.sv
// Shared types for the image LUT loader: FSM states and stream width helper.
// WAIT_SOF only exists when IMG_LUT_LOADER_FRAME_SYNC_EN is defined.
package img_proc_pkg;

`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_LOAD     = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
`endif

  // Pixel width rounded up to whole bytes for the stream bus.
  function automatic int tdata_width(input int px);
    return ((px + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/img_lut_loader_if.sv
// Stream input and LUT write-port interfaces for img_lut_loader.
// The ctrl port carries one table write per wr_stb.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 16
);
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (
    output tvalid, tlast, tuser, tdata,
    input  tready
  );
  modport slave (
    input  tvalid, tlast, tuser, tdata,
    output tready
  );
endinterface

interface img_lut_ctrl_if #(
  parameter int PX_WIDTH = 10
);
  logic [PX_WIDTH-1:0] orig_px;
  logic [PX_WIDTH-1:0] mod_px;
  logic                wr_stb;

  modport master (
    output orig_px, mod_px, wr_stb
  );
  modport slave (
    input  orig_px, mod_px, wr_stb
  );
endinterface

// File: rtl/img_lut_loader.sv
// Streams a full pixel LUT into the table write port, checking table length.
// Define IMG_LUT_LOADER_FRAME_SYNC_EN to hold the load until start-of-frame.
module img_lut_loader
  import img_proc_pkg::*;
#(
  parameter int PX_WIDTH = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           sof_i,
  axi4_stream_if.slave   lut_data_i,
  img_lut_ctrl_if.master img_lut_ctrl_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  localparam int CW = PX_WIDTH + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {PX_WIDTH{1'b1}}};

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PX_WIDTH-1:0] orig_q, orig_d;
  logic [PX_WIDTH-1:0] mod_q, mod_d;
  logic                tready;
  logic                acc;
  logic                unused;

  assign tready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign acc    = lut_data_i.tvalid & tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    orig_d  = orig_q;
    mod_d   = mod_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          cnt_d = '0;
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
          state_d = ST_WAIT_SOF;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
      ST_WAIT_SOF: begin
        if (sof_i) state_d = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        if (acc) begin
          stb_d  = 1'b1;
          orig_d = cnt_q[PX_WIDTH-1:0];
          mod_d  = lut_data_i.tdata[PX_WIDTH-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (lut_data_i.tlast) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (cnt_q != LAST) err_d = 1'b1;
          end else if (cnt_q == LAST) begin
            // Table overflow: keep the stream moving but stop writing.
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (acc && lut_data_i.tlast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      orig_q  <= '0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      orig_q  <= orig_d;
      mod_q   <= mod_d;
    end
  end

  assign lut_data_i.tready      = tready;
  assign img_lut_ctrl_o.wr_stb  = stb_q;
  assign img_lut_ctrl_o.orig_px = orig_q;
  assign img_lut_ctrl_o.mod_px  = mod_q;
  assign busy_o                 = (state_q != ST_IDLE);
  assign done_o                 = done_q;
  assign err_o                  = err_q;

  assign unused = ^{sof_i, lut_data_i.tuser, lut_data_i.tdata};

endmodule

// File: tb/tb_img_lut_loader.sv
// Randomized bench for img_lut_loader against a table-level reference model.
// Works with and without IMG_LUT_LOADER_FRAME_SYNC_EN.
module tb_img_lut_loader;
  import img_proc_pkg::*;

  localparam int PX    = 10;
  localparam int TW    = tdata_width(PX);
  localparam int DEPTH = 1 << PX;
  localparam int LAST  = DEPTH - 1;
`ifdef IMG_LUT_LOADER_FRAME_SYNC_EN
  localparam bit FSYNC = 1'b1;
`else
  localparam bit FSYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, sof;
  logic busy, done, err;

  axi4_stream_if #(.TDATA_WIDTH(TW)) s ();
  img_lut_ctrl_if #(.PX_WIDTH(PX)) c ();

  img_lut_loader #(.PX_WIDTH(PX)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .sof_i         (sof),
    .lut_data_i    (s),
    .img_lut_ctrl_o(c),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int mis = 0;
  bit chk_en = 1'b0;

  int wr_cnt, done_cnt, acc_cnt;
  int first_orig, first_mod, last_mod;

  logic [TW-1:0] dat [0:2047];

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: table-level rules, one step per cycle.
  bit            m_busy, m_sof, m_err;
  int            bidx;
  bit            e_stb, e_done;
  int            e_orig;
  logic [PX-1:0] e_mod;

  initial begin
    m_busy = 0; m_sof = 0; m_err = 0; bidx = 0;
    e_stb = 0; e_done = 0; e_orig = 0; e_mod = '0;
  end

  always @(negedge clk) begin
    bit et, acc;
    et = m_busy && m_sof;
    if (chk_en) begin
      chk("wr_stb", c.wr_stb, e_stb);
      if (e_stb && c.wr_stb === 1'b1) begin
        chk("orig_px", c.orig_px, e_orig);
        chk("mod_px", c.mod_px, e_mod);
      end
      chk("done", done, e_done);
      chk("err", err, m_err);
      chk("busy", busy, m_busy);
      chk("tready", s.tready, et);
    end
    if (c.wr_stb === 1'b1) begin
      if (wr_cnt == 0) begin
        first_orig = c.orig_px;
        first_mod  = c.mod_px;
      end
      last_mod = c.mod_px;
      wr_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      m_busy = 0; m_sof = 0; m_err = 0; bidx = 0;
      e_stb = 0; e_done = 0; e_orig = 0; e_mod = '0;
    end else begin
      acc    = et && s.tvalid;
      e_stb  = acc && bidx <= LAST;
      if (e_stb) begin
        e_orig = bidx;
        e_mod  = s.tdata[PX-1:0];
      end
      e_done = acc && s.tlast;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_sof = !FSYNC; m_err = 0; bidx = 0;
        end
      end else begin
        if (!m_sof && sof) m_sof = 1;
        if (acc) begin
          if (s.tlast) begin
            m_busy = 0;
            if (bidx < LAST) m_err = 1;
          end else if (bidx == LAST) begin
            m_err = 1;
          end
          acc_cnt++;
          bidx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int gap, input int rst_at);
    for (int i = 0; i < n; i++) begin
      int  hold;
      bit  ok;
      s.tvalid = 1'b0;
      if (gap > 0) repeat ($urandom_range(gap, 0)) tick();
      s.tvalid = 1'b1;
      s.tdata  = dat[i];
      s.tlast  = (i == n - 1);
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s.tvalid = 1'b0;
        s.tlast  = 1'b0;
        return;
      end
      hold = 0;
      ok   = 1'b0;
      do begin
        @(negedge clk);
        ok = (s.tready === 1'b1);
        tick();
        hold++;
      end while (!ok && hold < 5000);
      if (!ok) begin
        vec++;
        mis++;
        $display("FAIL beat_timeout: beat %0d not accepted in %0d cycles", i, hold);
        s.tvalid = 1'b0;
        s.tlast  = 1'b0;
        return;
      end
    end
    s.tvalid = 1'b0;
    s.tlast  = 1'b0;
  endtask

  task automatic do_load(input int n, input int gap, input bit ramp, input int rst_at);
    for (int i = 0; i < 2048; i++)
      dat[i] = ramp ? TW'(LAST - i) : TW'($urandom);
    wr_cnt = 0; done_cnt = 0; acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("err_clear_on_start", err, 0);
    chk("tready_after_start", s.tready, FSYNC ? 0 : 1);
    if (FSYNC) begin
      s.tvalid = 1'b1;
      s.tdata  = dat[0];
      s.tlast  = (n == 1);
    end
    repeat (5) tick();
    if (FSYNC) chk("no_write_before_sof", wr_cnt, 0);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    send(n, gap, rst_at);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sof = 1'b0;
    s.tvalid = 1'b0; s.tlast = 1'b0; s.tuser = 1'b0; s.tdata = '0;
    wr_cnt = 0; done_cnt = 0; acc_cnt = 0;
    first_orig = 0; first_mod = 0; last_mod = 0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_stb", c.wr_stb, 0);
    chk("rst_tready", s.tready, 0);
    chk("rst_orig", c.orig_px, 0);
    rst = 1'b0;
    tick();

    do_load(1024, 0, 1'b1, -1);
    chk("full_writes", wr_cnt, 1024);
    chk("full_done", done_cnt, 1);
    chk("full_err", err, 0);
    chk("full_first_orig", first_orig, 0);
    chk("full_first_mod", first_mod, 1023);
    chk("full_last_mod", last_mod, 0);

    do_load(100, 2, 1'b0, -1);
    chk("short_writes", wr_cnt, 100);
    chk("short_done", done_cnt, 1);
    chk("short_err", err, 1);

    do_load(1030, 1, 1'b0, -1);
    chk("long_writes", wr_cnt, 1024);
    chk("long_dropped", acc_cnt - wr_cnt, 6);
    chk("long_done", done_cnt, 1);
    chk("long_err", err, 1);

    do_load(1024, 2, 1'b0, 500);
    @(negedge clk);
    chk("abort_writes", wr_cnt, 500);
    chk("abort_done", done_cnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_stb", c.wr_stb, 0);
    chk("abort_tready", s.tready, 0);
    tick();

    do_load(1024, 3, 1'b0, -1);
    chk("after_abort_writes", wr_cnt, 1024);
    chk("after_abort_done", done_cnt, 1);
    chk("after_abort_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
